// File: rtl/fft_reorder_if.sv
// Sample stream bundle for fft_reorder; i_fftshift exists only when
// FFT_REORDER_FFTSHIFT_EN is defined.
interface fft_reorder_if #(
    parameter int unsigned WIDTH = 19
) ();
    logic               i_ce;
    logic               i_sync;
    logic               i_mode;
`ifdef FFT_REORDER_FFTSHIFT_EN
    logic               i_fftshift;
`endif
    logic [2*WIDTH-1:0] i_in;
    logic [2*WIDTH-1:0] o_out;
    logic               o_sync;
    logic               o_valid;
    logic               o_resync;

    modport master (
        output i_ce, i_sync, i_mode, i_in,
`ifdef FFT_REORDER_FFTSHIFT_EN
        output i_fftshift,
`endif
        input  o_out, o_sync, o_valid, o_resync
    );

    modport slave (
        input  i_ce, i_sync, i_mode, i_in,
`ifdef FFT_REORDER_FFTSHIFT_EN
        input  i_fftshift,
`endif
        output o_out, o_sync, o_valid, o_resync
    );
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong FFT output reorder: bit-reversed or pass-through per frame, latency N enables.
// Optional FFT_REORDER_FFTSHIFT_EN adds i_fftshift (rotate output index by N/2).
module fft_reorder #(
    parameter int unsigned LGSIZE = 4,
    parameter int unsigned WIDTH  = 19
) (
    input  logic         i_clk,
    input  logic         i_reset,
    fft_reorder_if.slave bus
);
    localparam int unsigned N  = 1 << LGSIZE;
    localparam int unsigned DW = 2 * WIDTH;
    localparam logic [LGSIZE-1:0] Half = LGSIZE'(N / 2);

    typedef enum logic {StIdle, StRun} state_e;

    state_e            r_state, w_state;
    logic [LGSIZE-1:0] r_cnt, w_cnt;
    logic              r_wbank, w_wbank;
    logic              r_full, w_full;
    logic [1:0]        r_bank_mode, w_bank_mode;
    logic [1:0]        r_bank_shift, w_bank_shift;
    logic [DW-1:0]     r_mem [2*N];
    logic [DW-1:0]     r_out;
    logic              r_sync, r_valid, r_resync;

    logic              w_we, w_fstart, w_resync, w_shift_in;
    logic              w_wsel, w_rbank;
    logic [LGSIZE-1:0] w_widx, w_ridx, w_sidx;
    logic [LGSIZE:0]   w_waddr, w_raddr;

`ifdef FFT_REORDER_FFTSHIFT_EN
    assign w_shift_in = bus.i_fftshift;
`else
    assign w_shift_in = 1'b0;
`endif

    function automatic logic [LGSIZE-1:0] bitrev(input logic [LGSIZE-1:0] v);
        logic [LGSIZE-1:0] w_rev;
        for (int unsigned b = 0; b < LGSIZE; b++) begin
            w_rev[b] = v[LGSIZE-1-b];
        end
        return w_rev;
    endfunction

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_wbank      = r_wbank;
        w_full       = r_full;
        w_bank_mode  = r_bank_mode;
        w_bank_shift = r_bank_shift;
        w_we         = 1'b0;
        w_fstart     = 1'b0;
        w_resync     = 1'b0;
        w_wsel       = r_wbank;
        if (bus.i_ce) begin
            unique case (r_state)
                StIdle: begin
                    if (bus.i_sync) begin
                        w_state  = StRun;
                        w_fstart = 1'b1;
                    end
                end
                StRun: begin
                    w_we     = 1'b1;
                    w_resync = bus.i_sync && (r_cnt != '0);
                    w_fstart = (r_cnt == '0) || w_resync;
                    // Reaching cnt==0 in RUN means the frame just written is whole.
                    if (r_cnt == '0) begin
                        w_full = 1'b1;
                    end else if (w_resync) begin
                        w_full = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (w_fstart) begin
            w_we                 = 1'b1;
            w_wsel               = ~r_wbank;
            w_wbank              = ~r_wbank;
            w_cnt                = LGSIZE'(1);
            w_bank_mode[w_wsel]  = bus.i_mode;
            w_bank_shift[w_wsel] = w_shift_in;
        end else if (w_we) begin
            w_cnt = r_cnt + 1'b1;
        end

        w_widx  = w_fstart ? '0 : r_cnt;
        w_waddr = {w_wsel, w_widx};
        // The read bank is always the one not being written; its own flags pick the order.
        w_rbank = ~w_wsel;
        w_sidx  = r_bank_shift[w_rbank] ? (w_widx ^ Half) : w_widx;
        w_ridx  = r_bank_mode[w_rbank] ? w_sidx : bitrev(w_sidx);
        w_raddr = {w_rbank, w_ridx};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_wbank      <= 1'b0;
            r_full       <= 1'b0;
            r_bank_mode  <= '0;
            r_bank_shift <= '0;
            r_out        <= '0;
            r_sync       <= 1'b0;
            r_valid      <= 1'b0;
            r_resync     <= 1'b0;
        end else if (bus.i_ce) begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_wbank      <= w_wbank;
            r_full       <= w_full;
            r_bank_mode  <= w_bank_mode;
            r_bank_shift <= w_bank_shift;
            r_out        <= w_full ? r_mem[w_raddr] : '0;
            r_sync       <= w_full && (w_widx == '0);
            r_valid      <= w_full;
            r_resync     <= w_resync;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_we) begin
            r_mem[w_waddr] <= bus.i_in;
        end
    end

    assign bus.o_out    = r_out;
    assign bus.o_sync   = r_sync;
    assign bus.o_valid  = r_valid;
    assign bus.o_resync = r_resync;
endmodule
